riscv_v_reduct_acc: RTL and testbench
=====================================

RISCV_V_REDUCT_ACC -- requirements
Module: riscv_v_reduct_acc

Interface
REQ-001 Parameter DATA_W, default 64: scalar accumulator width, equal to the largest element size.
REQ-002 Parameter CNT_W, default 4: width of the chunk counter; supports 0..8 chunks per reduction.
REQ-003 Clocking is fixed: one clock, clk; reset rst_n is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  request a new reduction; sampled only in IDLE.
REQ-007 num_chunks  in  CNT_W  number of adder result chunks to fold, one per register of the LMUL group.
REQ-008 osize_vector  in  4  one-hot element size: bit0=8, bit1=16, bit2=32, bit3=64.
REQ-009 is_signed  in  1  signed compare and signed overflow select.
REQ-010 reduct_op  in  2  reduct_op_t value: SUM=0, MAX=1, MIN=2, 3 reserved.
REQ-011 init_value  in  DATA_W  scalar seed, vs1[0].
REQ-012 in_valid / in_ready  in / out  1 / 1  chunk handshake from the vector adder's reduct output.
REQ-013 in_data  in  DATA_W  adder result bytes 0..7; the chunk's reduced element sits in its low SEW bits.
REQ-014 out_valid / out_ready  out / in  1 / 1  result handshake to writeback.
REQ-015 out_data  out  DATA_W  final scalar, zero-extended above SEW.
REQ-016 out_of  out  1  sticky overflow seen during a SUM reduction.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 States are IDLE, ACC and DONE; encoding is implementer's choice.
REQ-019 IDLE: in_ready=0 and out_valid=0. On start=1, latch op, size and sign, set acc = init_value masked to SEW, cnt = num_chunks, clear of_sticky. Next state is ACC, or DONE if num_chunks==0.
REQ-020 Non-one-hot osize_vector resolves to the lowest set bit; all-zero resolves to 64.
REQ-021 ACC: in_ready=1. On each in_valid&&in_ready beat, acc <= f(acc, in_data masked to SEW) and cnt decrements. The beat with cnt==1 moves to DONE.
REQ-022 SUM: acc <= (acc + x) mod 2^SEW. Signed overflow sets of_sticky when is_signed=1; carry-out of bit SEW-1 sets of_sticky when is_signed=0.
REQ-023 MAX/MIN: acc <= larger/smaller of acc and x under a signed or unsigned compare per is_signed; on a tie acc is unchanged.
REQ-024 Reserved op behaves as SUM and never sets of_sticky.
REQ-025 DONE: out_valid=1, out_data=acc, out_of=of_sticky. All three stay stable until out_ready=1, then the next state is IDLE.
REQ-026 Latency: start to the first in_ready is 1 cycle. The last accepted chunk to out_valid is 1 cycle.
REQ-027 start outside IDLE is ignored. in_valid outside ACC is not consumed. A DONE->IDLE cycle does not accept start in the same cycle.
REQ-028 Bits above SEW in in_data are ignored. acc bits above SEW are always 0.

Reset
REQ-029 While rst_n=0: state=IDLE; acc, cnt and of_sticky are 0; out_valid=0, in_ready=0, busy=0, out_data=0, out_of=0.
REQ-030 Reset asserted mid-reduction discards the partial result. No out_valid follows reset release until a new start.

Structure
REQ-031 reduct_op_t and its encodings, RISCV_V_REDUCT_CNT_W, and the osize-to-SEW-mask function belong in riscv_v_pkg. The existing osize_vector_t is reused.
REQ-032 The fold datapath (masked add, overflow and compare for one SEW) is the sub-module riscv_v_reduct_fold, which is purely combinational. The FSM and registers live in riscv_v_reduct_acc.

Verification
REQ-033 SUM, SEW=8, unsigned: init=0xF0, chunks 0x0F then 0x02 -> out_data=0x01, out_of=1.
REQ-034 MAX, SEW=16, signed: init=0x0001, chunks 0x8000 then 0x7FFF -> out_data=0x7FFF. The same case with is_signed=0 -> out_data=0x8000.
REQ-035 MIN, SEW=32, num_chunks=0: init=0x12345678 -> out_valid 1 cycle after start, out_data=0x12345678, no in_ready pulse.
REQ-036 Backpressure: SUM SEW=64 with 3 chunks, random in_valid gaps, out_ready held low 5 cycles -> out_data stable and equal to the exact 64-bit wrapped sum until accepted.
REQ-037 Reset mid-ACC after 1 of 4 chunks -> all outputs 0 and busy=0 immediately. A following start with chunks 1 and 2 -> out_data=init+3.
REQ-038 Upper-bit masking, SEW=8: in_data=0xFFFF_FFFF_FFFF_FF01 with init=0 -> out_data=0x01.

Source files
------------

// File: rtl/riscv_v_pkg.sv
// Shared vector-unit types: element-size vector, reduction opcodes and SEW helpers.
package riscv_v_pkg;

  localparam int RISCV_V_REDUCT_CNT_W = 4;

  // One-hot element size: bit0=8, bit1=16, bit2=32, bit3=64.
  typedef logic [3:0] osize_vector_t;

  typedef enum logic [1:0] {
    REDUCT_SUM  = 2'd0,
    REDUCT_MAX  = 2'd1,
    REDUCT_MIN  = 2'd2,
    REDUCT_RSVD = 2'd3
  } reduct_op_t;

  // Collapse any size vector to a clean one-hot: lowest set bit wins, zero means 64.
  function automatic osize_vector_t osize_resolve(input osize_vector_t osize);
    if (osize[0])      return 4'b0001;
    else if (osize[1]) return 4'b0010;
    else if (osize[2]) return 4'b0100;
    else               return 4'b1000;
  endfunction

  // Mask covering the low SEW bits of a 64-bit lane.
  function automatic logic [63:0] osize_to_sew_mask(input osize_vector_t osize);
    osize_vector_t r;
    r = osize_resolve(osize);
    case (r)
      4'b0001: return 64'h0000_0000_0000_00FF;
      4'b0010: return 64'h0000_0000_0000_FFFF;
      4'b0100: return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/riscv_v_reduct_fold.sv
// One reduction step for a single SEW: masked add with overflow, or signed/unsigned max/min.
module riscv_v_reduct_fold
  import riscv_v_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] x,
  input  osize_vector_t     osize,
  input  logic              is_signed,
  input  reduct_op_t        op,
  output logic [DATA_W-1:0] res,
  output logic              of_set
);

  logic [DATA_W-1:0]        mask;
  logic [DATA_W-1:0]        sbit;
  logic [DATA_W-1:0]        a;
  logic [DATA_W-1:0]        b;
  logic [DATA_W:0]          sum_full;
  logic [DATA_W-1:0]        sum_res;
  logic signed [DATA_W-1:0] a_sx;
  logic signed [DATA_W-1:0] b_sx;
  logic                     a_s, b_s, r_s, carry, sovf, b_gt, b_lt;

  // Combinational fold; the sign bit and carry bit are derived from the SEW mask itself.
  always_comb begin
    mask     = DATA_W'(osize_to_sew_mask(osize));
    sbit     = mask ^ (mask >> 1);
    a        = acc & mask;
    b        = x & mask;
    sum_full = {1'b0, a} + {1'b0, b};
    sum_res  = sum_full[DATA_W-1:0] & mask;
    carry    = |(sum_full & ({1'b0, mask} + 1'b1));
    a_s      = |(a & sbit);
    b_s      = |(b & sbit);
    r_s      = |(sum_res & sbit);
    sovf     = (a_s == b_s) && (r_s != a_s);
    // Sign-extend from the SEW sign bit: (v ^ s) - s.
    a_sx     = signed'((a ^ sbit) - sbit);
    b_sx     = signed'((b ^ sbit) - sbit);
    b_gt     = is_signed ? (b_sx > a_sx) : (b > a);
    b_lt     = is_signed ? (b_sx < a_sx) : (b < a);
    res      = sum_res;
    of_set   = 1'b0;
    case (op)
      REDUCT_SUM: begin
        res    = sum_res;
        of_set = is_signed ? sovf : carry;
      end
      REDUCT_MAX: res = b_gt ? b : a;
      REDUCT_MIN: res = b_lt ? b : a;
      default:    res = sum_res;
    endcase
  end

endmodule

// File: rtl/riscv_v_reduct_acc.sv
// Scalar reduction accumulator: seeds from vs1[0], folds one adder chunk per beat,
// then holds the result until writeback accepts it.
module riscv_v_reduct_acc
  import riscv_v_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = RISCV_V_REDUCT_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_chunks,
  input  osize_vector_t     osize_vector,
  input  logic              is_signed,
  input  logic [1:0]        reduct_op,
  input  logic [DATA_W-1:0] init_value,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_of,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic              of_sticky;
  reduct_op_t        op_q;
  osize_vector_t     size_q;
  logic              sign_q;
  logic [DATA_W-1:0] fold_res;
  logic              fold_of;

  riscv_v_reduct_fold #(.DATA_W(DATA_W)) u_fold (
    .acc       (acc),
    .x         (in_data),
    .osize     (size_q),
    .is_signed (sign_q),
    .op        (op_q),
    .res       (fold_res),
    .of_set    (fold_of)
  );

  assign out_data = acc;
  assign out_of   = of_sticky;

  // Control FSM with registered handshake outputs; acc is already zero above SEW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      of_sticky <= 1'b0;
      op_q      <= REDUCT_SUM;
      size_q    <= 4'b1000;
      sign_q    <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q      <= reduct_op_t'(reduct_op);
            size_q    <= osize_resolve(osize_vector);
            sign_q    <= is_signed;
            acc       <= init_value & DATA_W'(osize_to_sew_mask(osize_vector));
            cnt       <= num_chunks;
            of_sticky <= 1'b0;
            busy      <= 1'b1;
            if (num_chunks == '0) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
            end else begin
              state    <= ST_ACC;
              in_ready <= 1'b1;
            end
          end
        end
        ST_ACC: begin
          if (in_valid) begin
            acc       <= fold_res;
            of_sticky <= of_sticky | fold_of;
            cnt       <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              state     <= ST_DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_v_reduct_acc.sv
// Directed bench for riscv_v_reduct_acc with a result scoreboard and output monitor.
module tb_riscv_v_reduct_acc;
  import riscv_v_pkg::*;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [CNT_W-1:0]  num_chunks;
  osize_vector_t     osize_vector;
  logic              is_signed;
  logic [1:0]        reduct_op;
  logic [DATA_W-1:0] init_value;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_of;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W:0] sb_q[$];

  riscv_v_reduct_acc #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_chunks   (num_chunks),
    .osize_vector (osize_vector),
    .is_signed    (is_signed),
    .reduct_op    (reduct_op),
    .init_value   (init_value),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_of       (out_of),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle a result is presented it must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: got data 0x%0h with no result expected", out_data);
      end else begin
        if ({out_of, out_data} !== sb_q[0]) begin
          n_fail++;
          $display("FAIL result: got of=%0b data=0x%0h expected of=%0b data=0x%0h",
                   out_of, out_data, sb_q[0][DATA_W], sb_q[0][DATA_W-1:0]);
        end
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic feed_beat(input logic [63:0] d, input bit gaps);
    int k;
    if (gaps) repeat ($urandom_range(0, 3)) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    k = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      k++;
      if (k > 50) begin
        check("in_ready_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom();
  endtask

  task automatic run(input logic [1:0] op, input logic [3:0] sz, input logic sg,
                     input logic [63:0] init, input int n,
                     input logic [63:0] c0, input logic [63:0] c1, input logic [63:0] c2,
                     input logic [63:0] exp_d, input logic exp_o,
                     input bit gaps, input int hold);
    logic [63:0] ch [3];
    int k;
    ch[0] = c0; ch[1] = c1; ch[2] = c2;
    sb_q.push_back({exp_o, exp_d});
    out_ready    = (hold == 0);
    start        = 1'b1;
    reduct_op    = op;
    osize_vector = sz;
    is_signed    = sg;
    init_value   = init;
    num_chunks   = CNT_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    if (n == 0) begin
      @(negedge clk);
      check("zero_chunk_out_valid", {63'd0, out_valid}, 64'd1);
      check("zero_chunk_in_ready", {63'd0, in_ready}, 64'd0);
    end
    for (int i = 0; i < n; i++) feed_beat(ch[i], gaps);
    k = 0;
    forever begin
      if (out_valid) break;
      @(negedge clk);
      k++;
      if (k > 50) begin
        check("out_valid_timeout", 64'd0, 64'd1);
        break;
      end
    end
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1 out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_chunks = '0; osize_vector = '0; is_signed = 1'b0;
    reduct_op = 2'd0; init_value = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready",  {63'd0, in_ready},  64'd0);
    check("rst_busy",      {63'd0, busy},      64'd0);
    check("rst_out_data",  out_data,           64'd0);
    check("rst_out_of",    {63'd0, out_of},    64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SUM SEW=8 unsigned with carry-out
    run(2'd0, 4'b0001, 1'b0, 64'hF0, 2, 64'h0F, 64'h02, 64'h0, 64'h01, 1'b1, 1'b0, 0);
    // MAX SEW=16 signed / unsigned
    run(2'd1, 4'b0010, 1'b1, 64'h1, 2, 64'h8000, 64'h7FFF, 64'h0, 64'h7FFF, 1'b0, 1'b0, 0);
    run(2'd1, 4'b0010, 1'b0, 64'h1, 2, 64'h8000, 64'h7FFF, 64'h0, 64'h8000, 1'b0, 1'b0, 0);
    // MIN SEW=32 with zero chunks
    run(2'd2, 4'b0100, 1'b0, 64'h12345678, 0, 64'h0, 64'h0, 64'h0, 64'h12345678, 1'b0, 1'b0, 0);
    // SUM SEW=64 with input gaps and writeback backpressure
    run(2'd0, 4'b1000, 1'b0, 64'h10, 3, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20,
        64'h8000_0000_0000_0000, 64'h8000_0000_0000_0020, 1'b1, 1'b1, 5);
    // Upper-bit masking of in_data at SEW=8
    run(2'd0, 4'b0001, 1'b0, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FF01, 64'h0, 64'h0, 64'h01, 1'b0, 1'b0, 0);
    // Signed SUM overflow at SEW=16
    run(2'd0, 4'b0010, 1'b1, 64'h7FFF, 1, 64'h0001, 64'h0, 64'h0, 64'h8000, 1'b1, 1'b0, 0);
    // Signed MIN at SEW=8
    run(2'd2, 4'b0001, 1'b1, 64'h05, 2, 64'hFE, 64'h80, 64'h0, 64'h80, 1'b0, 1'b0, 0);
    // Reserved op adds but never flags overflow
    run(2'd3, 4'b0001, 1'b0, 64'hFF, 1, 64'h01, 64'h0, 64'h0, 64'h00, 1'b0, 1'b0, 0);
    // Non-one-hot size picks the lowest bit (SEW=16)
    run(2'd0, 4'b0110, 1'b0, 64'hFFFF, 1, 64'h0002, 64'h0, 64'h0, 64'h0001, 1'b1, 1'b0, 0);
    // All-zero size means SEW=64
    run(2'd0, 4'b0000, 1'b0, 64'h1_0000_0000, 1, 64'h1, 64'h0, 64'h0, 64'h1_0000_0001, 1'b0, 1'b0, 0);
    // Seed masked to SEW
    run(2'd0, 4'b0001, 1'b0, 64'h1234, 0, 64'h0, 64'h0, 64'h0, 64'h34, 1'b0, 1'b0, 0);

    // Reset in the middle of a 4-chunk reduction
    start = 1'b1; reduct_op = 2'd0; osize_vector = 4'b0100; is_signed = 1'b0;
    init_value = 64'h100; num_chunks = CNT_W'(4);
    @(posedge clk); #1;
    start = 1'b0;
    feed_beat(64'h5, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_in_ready",  {63'd0, in_ready},  64'd0);
    check("midrst_busy",      {63'd0, busy},      64'd0);
    check("midrst_out_data",  out_data,           64'd0);
    check("midrst_out_of",    {63'd0, out_of},    64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle", {63'd0, out_valid}, 64'd0);
    end
    @(posedge clk); #1;
    run(2'd0, 4'b0100, 1'b0, 64'h100, 2, 64'h1, 64'h2, 64'h0, 64'h103, 1'b0, 1'b0, 0);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
